// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC dot-product operand sequencer.
package mac_seq_pkg;

  localparam int DEF_OPW   = 4;
  localparam int DEF_ACCW  = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_LENW  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    RESULT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous operand FIFO, first-word-fall-through read, synchronous active-low reset.
module mac_seq_fifo
  import mac_seq_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_OPW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mac_dot_sequencer.sv
// Buffers operand pairs and issues LEN of them to the MAC, then returns the dot product.
// Optional overflow flag enabled by defining MAC_SEQ_OVF_EN.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int OPW   = DEF_OPW,
  parameter int ACCW  = DEF_ACCW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LENW  = DEF_LENW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LENW-1:0] len_in,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  output logic [OPW-1:0]  mac_a,
  output logic [OPW-1:0]  mac_b,
  output logic            mac_en,
  output logic            mac_clr,
  input  logic [ACCW-1:0] mac_acc,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data,
  output logic            res_ovf
);

  state_t            state;
  logic [LENW-1:0]   len_reg;
  logic [LENW-1:0]   cnt;
  logic              drain_second;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*OPW-1:0]  fifo_rdata;
  logic              push;
  logic              pop;
  logic              ovf_now;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state == RUN) && !fifo_empty;

  mac_seq_fifo #(
    .WIDTH(2 * OPW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata({in_a, in_b}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef MAC_SEQ_OVF_EN
  localparam int SW = ACCW + LENW;
  logic [SW-1:0] shadow;

  always_ff @(posedge clk) begin
    if (!rst_n || state == CLEAR) begin
      shadow <= '0;
    end else if (mac_en) begin
      shadow <= shadow + (SW'(mac_a) * SW'(mac_b));
    end
  end

  assign ovf_now = |shadow[SW-1:ACCW];
`else
  assign ovf_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_reg      <= '0;
      cnt          <= '0;
      drain_second <= 1'b0;
      busy         <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_ovf      <= 1'b0;
    end else begin
      // Operands default to zero: the MAC accumulates on every clock.
      mac_a   <= '0;
      mac_b   <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_in != '0) begin
            len_reg <= len_in;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (pop) begin
            mac_a  <= fifo_rdata[2*OPW-1:OPW];
            mac_b  <= fifo_rdata[OPW-1:0];
            mac_en <= 1'b1;
            cnt    <= cnt + LENW'(1);
            if (cnt + LENW'(1) == len_reg) begin
              drain_second <= 1'b0;
              state        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Second drain cycle: the last product has reached mac_acc.
          if (drain_second) begin
            res_data  <= mac_acc;
            res_ovf   <= ovf_now;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            drain_second <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized self-checking bench for mac_dot_sequencer with a behavioural MAC and pair-queue model.
module tb_mac_dot_sequencer;

  localparam int OPW   = 4;
  localparam int ACCW  = 8;
  localparam int DEPTH = 4;
  localparam int LENW  = 4;
`ifdef MAC_SEQ_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } pair_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [LENW-1:0] len_in;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a;
  logic [OPW-1:0]  in_b;
  logic [OPW-1:0]  mac_a;
  logic [OPW-1:0]  mac_b;
  logic            mac_en;
  logic            mac_clr;
  logic [ACCW-1:0] mac_acc;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_data;
  logic            res_ovf;

  int nvec = 0;
  int nerr = 0;
  pair_t exp_q[$];
  pair_t feed_q[$];

  always #5 clk = ~clk;

  // Behavioural MAC: accumulator updates one clock after its operands.
  always @(posedge clk) begin
    if (!rst_n || mac_clr) mac_acc <= '0;
    else mac_acc <= mac_acc + (ACCW'(mac_a) * ACCW'(mac_b));
  end

  mac_dot_sequencer #(
    .OPW(OPW), .ACCW(ACCW), .DEPTH(DEPTH), .LENW(LENW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_in(len_in), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf)
  );

  task automatic push_idle(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic exp_rdy;
    pair_t p;
    @(negedge clk);
    exp_rdy = (exp_q.size() < DEPTH);
    in_valid = 1'b1; in_a = a; in_b = b;
    nvec++;
    if (in_ready !== exp_rdy) begin
      nerr++;
      $display("FAIL push_ready: in_ready=%b expected %b (occupancy %0d)", in_ready, exp_rdy, exp_q.size());
    end
    if (in_ready) begin
      p.a = a; p.b = b;
      exp_q.push_back(p);
    end
    $display("push (%0d,%0d) ready=%b", a, b, in_ready);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One dot product: start, watch the issue stream, feed feed_q, check result, optionally stall.
  task automatic run_dot(input int len, input int lat, input int gap, input int hold);
    int c, issued, sum, gapc;
    bit done;
    pair_t p;
    logic [ACCW-1:0] exp_d;
    logic exp_o;
    @(negedge clk);
    start = 1'b1; len_in = LENW'(len);
    c = 0; issued = 0; sum = 0; gapc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      nvec++;
      if (mac_clr !== (c == 1)) begin
        nerr++;
        $display("FAIL mac_clr: cycle %0d got %b expected %b", c, mac_clr, (c == 1));
      end
      if (mac_en) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL extra_issue: cycle %0d pair (%0d,%0d) issued but none expected", c, mac_a, mac_b);
        end else begin
          p = exp_q.pop_front();
          if ({mac_a, mac_b} !== {p.a, p.b}) begin
            nerr++;
            $display("FAIL issue_pair: cycle %0d got (%0d,%0d) expected (%0d,%0d)", c, mac_a, mac_b, p.a, p.b);
          end
          sum += int'(p.a) * int'(p.b);
        end
        issued++;
      end else begin
        nvec++;
        if (mac_a !== '0 || mac_b !== '0) begin
          nerr++;
          $display("FAIL bubble_zero: cycle %0d got (%0d,%0d) expected (0,0)", c, mac_a, mac_b);
        end
      end
      nvec++;
      if (busy !== 1'b1) begin
        nerr++;
        $display("FAIL busy_run: cycle %0d got %b expected 1", c, busy);
      end
      in_valid = 1'b0;
      if (res_valid) begin
        done = 1;
      end else if (c >= 200) begin
        nvec++; nerr++;
        $display("FAIL timeout: res_valid not seen after %0d cycles expected within %0d", c, len + 4);
        done = 1;
      end else if (feed_q.size() > 0) begin
        if (gapc > 0) begin
          gapc--;
        end else begin
          in_valid = 1'b1; in_a = feed_q[0].a; in_b = feed_q[0].b;
          if (in_ready) begin
            exp_q.push_back(feed_q.pop_front());
            gapc = gap;
          end
        end
      end
    end
    in_valid = 1'b0;
    exp_d = ACCW'(sum);
    exp_o = OVF && (sum > (1 << ACCW) - 1);
    nvec++;
    if (issued != len) begin
      nerr++;
      $display("FAIL issue_count: got %0d expected %0d", issued, len);
    end
    nvec++;
    if (res_data !== exp_d) begin
      nerr++;
      $display("FAIL res_data: got %0d expected %0d", res_data, exp_d);
    end
    nvec++;
    if (res_ovf !== exp_o) begin
      nerr++;
      $display("FAIL res_ovf: got %b expected %b", res_ovf, exp_o);
    end
    if (lat > 0) begin
      nvec++;
      if (c != lat) begin
        nerr++;
        $display("FAIL latency: got %0d expected %0d", c, lat);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = (h == 1); len_in = LENW'(3);
      nvec++;
      if (res_valid !== 1'b1 || res_data !== exp_d || busy !== 1'b1 || mac_clr !== 1'b0) begin
        nerr++;
        $display("FAIL result_hold: cycle %0d valid=%b data=%0d busy=%b clr=%b expected 1,%0d,1,0",
                 h, res_valid, res_data, busy, mac_clr, exp_d);
      end
    end
    @(negedge clk);
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    nvec++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || mac_clr !== 1'b0) begin
      nerr++;
      $display("FAIL result_accept: valid=%b busy=%b clr=%b expected 0,0,0", res_valid, busy, mac_clr);
    end
    $display("dot len=%0d result=%0d ovf=%b cycles=%0d", len, res_data, res_ovf, c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_ovf} !==
        {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: busy=%b rdy=%b a=%0d b=%0d en=%b clr=%b rv=%b rd=%0d ovf=%b expected 0 1 0 0 0 0 0 0 0",
               busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_ovf);
    end
    rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_basic();
    push_idle(4'd2, 4'd3);
    push_idle(4'd4, 4'd5);
    push_idle(4'd1, 4'd7);
    run_dot(3, 7, 0, 0);
  endtask

  task automatic test_backpressure();
    pair_t p;
    for (int i = 0; i < DEPTH; i++) push_idle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    p.a = 4'($urandom_range(0, 15));
    p.b = 4'($urandom_range(0, 15));
    push_idle(p.a, p.b);
    feed_q.push_back(p);
    run_dot(2, 6, 0, 0);
    nvec++;
    if (feed_q.size() != 0) begin
      nerr++;
      $display("FAIL held_push: %0d pairs still waiting expected 0", feed_q.size());
    end
    run_dot(3, 7, 0, 0);
  endtask

  task automatic test_overflow();
    push_idle(4'd15, 4'd15);
    push_idle(4'd15, 4'd15);
    run_dot(2, 6, 0, 0);
  endtask

  task automatic test_gaps();
    pair_t p;
    for (int i = 0; i < 2; i++) begin
      p.a = 4'($urandom_range(1, 15));
      p.b = 4'($urandom_range(1, 15));
      feed_q.push_back(p);
    end
    run_dot(2, -1, 3, 0);
  endtask

  task automatic test_hold_ignore();
    push_idle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    run_dot(1, 5, 0, 5);
    @(negedge clk);
    start = 1'b1; len_in = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      nvec++;
      if (busy !== 1'b0 || mac_clr !== 1'b0) begin
        nerr++;
        $display("FAIL len0_ignored: busy=%b clr=%b expected 0,0", busy, mac_clr);
      end
    end
  endtask

  task automatic test_random();
    pair_t p;
    int len, pre;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 7);
      pre = $urandom_range(0, DEPTH - exp_q.size());
      for (int i = 0; i < pre; i++) push_idle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int i = exp_q.size(); i < len; i++) begin
        p.a = 4'($urandom_range(0, 15));
        p.b = 4'($urandom_range(0, 15));
        feed_q.push_back(p);
      end
      run_dot(len, (feed_q.size() == 0) ? len + 4 : -1, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    if (exp_q.size() > 0) run_dot(exp_q.size(), exp_q.size() + 4, 0, 0);
  endtask

  task automatic test_midrun_reset();
    push_idle(4'd9, 4'd9);
    push_idle(4'd8, 4'd7);
    push_idle(4'd6, 4'd5);
    @(negedge clk);
    start = 1'b1; len_in = LENW'(3);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_ovf} !==
        {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL midrun_reset: busy=%b rdy=%b a=%0d b=%0d en=%b clr=%b rv=%b rd=%0d ovf=%b expected 0 1 0 0 0 0 0 0 0",
               busy, in_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, res_ovf);
    end
    rst_n = 1'b1;
    exp_q.delete();
    push_idle(4'd3, 4'd4);
    run_dot(1, 5, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len_in = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_gaps();
    test_hold_ignore();
    test_random();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
